// File: rtl/resp_sig_pkg.sv
// Shared types and constants for the response signature checker.
// Holds the FSM state enum, default MISR constants and a 16-bit MISR step model.
package resp_sig_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int          DEF_SIG_W = 16;
   localparam logic [15:0] DEF_POLY  = 16'h1021;
   localparam logic [15:0] DEF_SEED  = 16'hFFFF;

   // One MISR step with the default polynomial; data is already zero-extended.
   function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] data);
      logic [15:0] fb;
      fb = sig[15] ? DEF_POLY : 16'h0000;
      return {sig[14:0], 1'b0} ^ fb ^ data;
   endfunction

endpackage

// File: rtl/resp_toggle_mon.sv
// Per-bit saturating toggle counters against the previously accepted vector.
// A bit is flagged unstable once its counter saturates at CNT_MAX.
module resp_toggle_mon #(
   parameter int WIDTH   = 6,
   parameter int CNT_MAX = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] unstable
);

   localparam int CW = $clog2(CNT_MAX + 1);

   logic [WIDTH-1:0] prev;
   logic [CW-1:0]    cnt [WIDTH];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         prev <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         if (load || en) prev <= data;
         if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
               if ((data[i] != prev[i]) && (cnt[i] != CW'(CNT_MAX)))
                  cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Saturated counters never decrement, so the flag is sticky until clear.
   always_comb begin
      unstable = '0;
      for (int i = 0; i < WIDTH; i++) unstable[i] = (cnt[i] == CW'(CNT_MAX));
   end

endmodule

// File: rtl/resp_sig_checker.sv
// MISR-compacting response checker with per-bit oscillation detection and a windowed verdict.
// Define RESP_SIG_TIMEOUT_EN to abort a window after 2^WIN_W consecutive idle RUN cycles.
module resp_sig_checker
   import resp_sig_pkg::*;
#(
   parameter int               WIDTH      = 6,
   parameter int               SIG_W      = 16,
   parameter logic [SIG_W-1:0] POLY       = DEF_POLY,
   parameter logic [SIG_W-1:0] SEED       = DEF_SEED,
   parameter int               WIN_W      = 8,
   parameter int               TOGGLE_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIN_W-1:0] window_len,
   input  logic [SIG_W-1:0] exp_sig,
   input  logic             vec_valid,
   input  logic [WIDTH-1:0] vec_data,
   output logic             vec_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [WIDTH-1:0] unstable,
   output logic             timeout,
   output state_t           state
);

   // Handshake: a vector is consumed on any cycle with vec_valid && vec_ready;
   // vec_ready is a pure function of state (high throughout RUN), so no backpressure.

   state_t           state_next;
   logic [SIG_W-1:0] sig;
   logic [SIG_W-1:0] sig_next;
   logic [SIG_W-1:0] exp_lat;
   logic [WIN_W-1:0] win_len;
   logic [WIN_W-1:0] acc_cnt;
   logic [WIN_W-1:0] acc_inc;
   logic             seen_first;
   logic             accept;
   logic             start_take;
   logic             timeout_hit;

   assign accept     = vec_valid && (state == RUN);
   assign start_take = start && ((state == IDLE) || (state == DONE));
   assign acc_inc    = acc_cnt + 1'b1;
   assign sig_next   = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(vec_data);

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (start) state_next = (window_len == '0) ? DONE : RUN;
         RUN: begin
            if (accept && (acc_inc == win_len)) state_next = DONE;
            else if (timeout_hit)               state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sig        <= SEED;
         exp_lat    <= '0;
         win_len    <= '0;
         acc_cnt    <= '0;
         seen_first <= 1'b0;
      end else begin
         state <= state_next;
         if (start_take) begin
            sig        <= SEED;
            exp_lat    <= exp_sig;
            win_len    <= window_len;
            acc_cnt    <= '0;
            seen_first <= 1'b0;
         end else if (accept) begin
            sig        <= sig_next;
            acc_cnt    <= acc_inc;
            seen_first <= 1'b1;
         end
      end
   end

`ifdef RESP_SIG_TIMEOUT_EN
   logic [WIN_W:0] idle_cnt;
   logic [WIN_W:0] idle_inc;
   logic           timeout_q;

   assign idle_inc    = idle_cnt + 1'b1;
   // Fires on the 2^WIN_W-th consecutive idle RUN cycle.
   assign timeout_hit = (state == RUN) && !accept && idle_inc[WIN_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (start_take || accept || (state != RUN)) idle_cnt <= '0;
         else                                       idle_cnt <= idle_inc;
         if (start_take)       timeout_q <= 1'b0;
         else if (timeout_hit) timeout_q <= 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout     = 1'b0;
`endif

   resp_toggle_mon #(
      .WIDTH   (WIDTH),
      .CNT_MAX (TOGGLE_MAX + 1)
   ) u_toggle_mon (
      .clk      (clk),
      .rst      (rst),
      .clear    (start_take),
      .load     (accept && !seen_first),
      .en       (accept && seen_first),
      .data     (vec_data),
      .unstable (unstable)
   );

   // Signature and unstable are frozen in DONE, so a combinational verdict holds too.
   assign pass      = (state == DONE) && !timeout && (sig == exp_lat) && (unstable == '0);
   assign vec_ready = (state == RUN);
   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign signature = sig;

endmodule

// File: doc/resp_sig_checker.md
Name: resp_sig_checker

Overview:
- Response-side companion to the gate-level test DUTs driven by the simulator bench.
- Consumes the DUT output vector stream one vector per handshake.
- Compacts accepted vectors into a MISR signature and flags output bits that toggle excessively, which indicates oscillating or combinational-loop nets.
- At the end of a programmable window it reports a pass/fail verdict against an expected signature.

Parameters:
- WIDTH, 6: observed DUT output vector width.
- SIG_W, 16: MISR signature width; must be >= WIDTH.
- POLY, 16'h1021: MISR feedback polynomial, SIG_W bits.
- SEED, 16'hFFFF: MISR value loaded on start.
- WIN_W, 8: width of the window length and counters.
- TOGGLE_MAX, 4: maximum toggles per bit allowed in one window.

Ports:
- clk, in, 1: single clock; all logic is rising-edge.
- rst, in, 1: reset, synchronous, active-high.
- start, in, 1: one-cycle pulse that begins a window; honoured in IDLE and DONE only.
- window_len, in, WIN_W: number of vectors to accept; sampled on start.
- exp_sig, in, SIG_W: expected signature; sampled on start.
- vec_valid, in, 1: vec_data is valid.
- vec_data, in, WIDTH: DUT output vector.
- vec_ready, out, 1: high only in RUN.
- busy, out, 1: high in RUN.
- done, out, 1: high in DONE.
- pass, out, 1: verdict; meaningful while done.
- signature, out, SIG_W: current MISR value.
- unstable, out, WIDTH: sticky per-bit toggle-overflow flags.
- timeout, out, 1: see Optional Feature.

Behaviour:
- Reset value of every output is 0, except signature = SEED. FSM returns to IDLE; all counters clear. Reset mid-RUN abandons the window.
- FSM states are IDLE, RUN, DONE.
- IDLE or DONE with start=1 (next cycle):
  - signature is set to SEED; unstable, toggle counters, accept count and first-vector flag clear; window_len and exp_sig are latched.
  - If latched window_len==0, go to DONE with pass = (SEED==exp_sig).
  - Otherwise go to RUN.
- RUN: a vector is accepted when vec_valid && vec_ready. There is no backpressure; ready stays 1 throughout RUN.
- MISR update per accepted vector: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero_ext(vec_data). The result is visible on signature the cycle after acceptance.
- Toggle tracking:
  - The first accepted vector only loads the previous-vector register and counts no toggles.
  - Each later accepted vector increments the counter of each bit that differs from the previous vector; counters saturate at TOGGLE_MAX+1.
  - unstable[i] sets when counter i reaches TOGGLE_MAX+1.
- On the cycle the accept count reaches the latched window_len:
  - Go to DONE; done=1 on the next cycle.
  - pass = (final signature==exp_sig) && (unstable==0), using the values that include the last vector.
- DONE holds all outputs until start or rst.
- start during RUN is ignored. vec_valid in IDLE or DONE is ignored (ready=0).
- start and rst in the same cycle: rst wins.
- The accept counter is WIN_W bits and cannot wrap, because window_len <= 2^WIN_W-1.

Optional Feature:
- Macro RESP_SIG_TIMEOUT_EN.
- Defined: an idle counter (WIN_W+1 bits) counts consecutive RUN cycles with no accepted vector and clears on every accept.
  - At 2^WIN_W idle cycles the block goes to DONE with pass=0 and timeout=1.
  - timeout clears on start or rst.
- Undefined: no idle counter; timeout is tied to 0; RUN waits indefinitely.

Decomposition:
- Package resp_sig_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default POLY and SEED constants;
  - a misr_step function for use by the bench model.
- One sub-module, resp_toggle_mon: per-bit saturating toggle counters plus previous-vector register, with load/clear/enable inputs and an unstable output.
- MISR and FSM stay in the top.

Test Plan:
- Single vector: window_len=1, exp_sig=16'hEFF5, vec_data=6'h2A -> signature=16'hEFF5, done=1, pass=1, unstable=0.
- Zero window: window_len=0, exp_sig=16'hFFFF, start -> done=1, pass=1 one cycle later, vec_ready never high.
- Oscillation: bit0 alternating 0,1,0,1,0,1, other bits 0, window_len=6 -> 5 toggles, unstable=6'b000001, pass=0. The same pattern with window_len=5 gives 4 toggles -> unstable=0.
- Gapped valid: 4 vectors with 3 idle cycles between each -> signature equals the bench misr_step result; done arrives after the 4th accept.
- Reset in RUN: rst after 2 of 8 vectors -> state IDLE, signature=16'hFFFF, unstable=0. A following start runs a clean window.
- Timeout (RESP_SIG_TIMEOUT_EN, WIN_W=8): start, then no valid for 256 cycles -> done=1, timeout=1, pass=0.
